mem_wb_stage_reg: RTL and testbench
===================================

# mem_wb_stage_reg

Parametrised MEM→WB pipeline stage register for the ASIP datapath. It carries the memory read data, the ALU result, the destination register address and the write-back control bits (PCSrc, regWrite, memToReg) from the MEM stage to the WB stage. Data moves under a valid/ready handshake, and the block supports stall, flush and an optional two-entry skid buffer. Every output has a defined reset value. Control outputs are gated so that a bubble never writes the register file or redirects the PC.

## Interface
- DATA_W, 24, width of memory read data (RD / ReadData)
- ALU_W, 16, width of ALU result (ALUOutM / AluOutW)
- RA_W, 4, width of destination register address (WA3M / WA3W)

- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  MEM stage presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  synchronous kill of all held and incoming entries
- RD  in  DATA_W  memory read data
- ALUOutM  in  ALU_W  ALU result
- WA3M  in  RA_W  destination register
- PCSrcM, regWriteM, memToRegM  in  1 each  control bits
- out_valid  out  1  WB-side entry valid
- out_ready  in  1  WB stage consumes the entry (0 = stall)
- ReadData  out  DATA_W;  AluOutW  out  ALU_W;  WA3W  out  RA_W
- PCSrcW, regWriteW, memToRegW  out  1 each

## Operation
- Accept: in_valid && in_ready && !flush. Drain: out_valid && out_ready.
- Main register M drives all W outputs. M loads on an accept when it is empty or draining; otherwise M holds (stall).
- PCSrcW and regWriteW are registered bit AND out_valid. memToRegW and the data fields show the held value and are don't-care when out_valid=0.
- flush=1: M.valid and S.valid (if present) clear at the edge. An input offered in the same cycle is dropped. Flush has priority over accept, drain and reset release. Data fields are not cleared.
- Reset (rst=0, any time including mid-transfer): all valids 0 and all outputs 0 immediately (asynchronous). After release, in_ready=1 and the first accepted entry appears on the next edge.

## Timing
- Latency: 1 cycle from accept to out_valid with the payload.
- Throughput: 1 entry per cycle while out_ready=1.
- Without skid: in_ready = out_ready || !M.valid (combinational through-path).
- With skid: in_ready = !S.valid (registered, no out_ready→in_ready path). If an accept occurs while M is valid and not draining, the entry goes to skid register S. On the next M load, S moves to M ahead of new input, so order is preserved. S is then refilled the same cycle if an accept occurs.
- Simultaneous accept and drain with S empty: M loads new data and no bubble is inserted.
- Both entries full and out_ready=0: in_ready=0 and the contents hold indefinitely.

## Configuration
- MEM_WB_SKID_EN defined: the two-entry skid buffer is compiled in, in_ready is registered, and two entries can be held.
- MEM_WB_SKID_EN undefined: there is no S register, in_ready is combinational as above, and one entry can be held.

## Test plan
- Reset: drive rst=0 mid-stream with M valid (ALUOutM=16'h1234) → all outputs 0 without waiting for a clock edge; after release in_ready=1 and out_valid=0.
- Streaming: out_ready=1 with entries ALUOutM=1,2,3 on consecutive cycles → AluOutW=1,2,3 each one cycle later, out_valid high for 3 cycles.
- Stall: entry A (WA3M=4'h5, regWriteM=1) accepted, then out_ready=0 for 4 cycles → WA3W=5 and regWriteW=1 held. Without skid, in_ready=0. With skid, one more entry B is accepted, then in_ready=0. After release, A then B are delivered.
- Flush: M valid with PCSrcM=1, assert flush together with in_valid for entry C → next cycle out_valid=0, PCSrcW=0, regWriteW=0, and C is never output.
- Bubble gating: in_valid=0 with regWriteM=1 and PCSrcM=1 on the inputs → regWriteW=0 and PCSrcW=0.
- Width parameters: DATA_W=32, ALU_W=32, RA_W=5 with RD=32'hDEADBEEF and WA3M=5'd31 → ReadData=32'hDEADBEEF and WA3W=31 after 1 cycle.

Source files
------------

// File: rtl/mem_wb_stage_reg.sv
// mem_wb_stage_reg: MEM->WB pipeline stage register with valid/ready handshake,
// stall, synchronous flush and gated write-back control outputs.
// Optional feature macro: MEM_WB_SKID_EN adds a second (skid) entry so that
// in_ready comes from a register instead of a combinational out_ready path.
module mem_wb_stage_reg #(
    parameter int DATA_W = 24,
    parameter int ALU_W  = 16,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] RD,
    input  logic [ALU_W-1:0]  ALUOutM,
    input  logic [RA_W-1:0]   WA3M,
    input  logic              PCSrcM,
    input  logic              regWriteM,
    input  logic              memToRegM,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ReadData,
    output logic [ALU_W-1:0]  AluOutW,
    output logic [RA_W-1:0]   WA3W,
    output logic              PCSrcW,
    output logic              regWriteW,
    output logic              memToRegW
);

    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic [ALU_W-1:0]  alu;
        logic [RA_W-1:0]   wa;
        logic              pc;
        logic              rw;
        logic              m2r;
    } payload_t;

    payload_t in_pl_s;
    payload_t m_pl_q, m_pl_d;
    logic     m_valid_q, m_valid_d;
    logic     in_ready_s;
    logic     accept_s;

    // Bundle the MEM-side fields into one payload word.
    always_comb begin
        in_pl_s     = '0;
        in_pl_s.rd  = RD;
        in_pl_s.alu = ALUOutM;
        in_pl_s.wa  = WA3M;
        in_pl_s.pc  = PCSrcM;
        in_pl_s.rw  = regWriteM;
        in_pl_s.m2r = memToRegM;
    end

    assign accept_s = in_valid & in_ready_s & ~flush;
    assign in_ready = in_ready_s;

`ifdef MEM_WB_SKID_EN
    payload_t s_pl_q, s_pl_d;
    logic     s_valid_q, s_valid_d;

    // Ready depends only on the skid entry, so it is free of out_ready;
    // held low while reset is asserted so every output reads 0.
    assign in_ready_s = rst & ~s_valid_q;

    // Next state for M and S: S always refills M first to keep order.
    always_comb begin
        m_pl_d    = m_pl_q;
        m_valid_d = m_valid_q;
        s_pl_d    = s_pl_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || out_ready) begin
            if (s_valid_q) begin
                m_pl_d    = s_pl_q;
                m_valid_d = 1'b1;
                if (accept_s) begin
                    s_pl_d    = in_pl_s;
                    s_valid_d = 1'b1;
                end else begin
                    s_valid_d = 1'b0;
                end
            end else if (accept_s) begin
                m_pl_d    = in_pl_s;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            s_pl_d    = in_pl_s;
            s_valid_d = 1'b1;
        end else begin
            s_valid_d = s_valid_q;
        end
    end

    // Skid entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_pl_q    <= '0;
            s_valid_q <= 1'b0;
        end else begin
            s_pl_q    <= s_pl_d;
            s_valid_q <= s_valid_d;
        end
    end
`else
    // Single entry: can take new data whenever M is empty or draining.
    assign in_ready_s = rst & (out_ready | ~m_valid_q);

    // Next state for M: flush beats accept, accept beats drain.
    always_comb begin
        m_pl_d    = m_pl_q;
        m_valid_d = m_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (accept_s) begin
            m_pl_d    = in_pl_s;
            m_valid_d = 1'b1;
        end else if (m_valid_q && out_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end
`endif

    // Main entry storage; drives every WB-side output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pl_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            m_pl_q    <= m_pl_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign out_valid = m_valid_q;
    assign ReadData  = m_pl_q.rd;
    assign AluOutW   = m_pl_q.alu;
    assign WA3W      = m_pl_q.wa;
    assign memToRegW = m_pl_q.m2r;
    // A bubble must never redirect the PC or write the register file.
    assign PCSrcW    = m_pl_q.pc & m_valid_q;
    assign regWriteW = m_pl_q.rw & m_valid_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Self-checking bench for mem_wb_stage_reg: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_mem_wb_stage_reg;

    typedef struct packed {
        logic [23:0] rd;
        logic [15:0] alu;
        logic [3:0]  wa;
        logic        pc;
        logic        rw;
        logic        m2r;
    } item_t;

    typedef struct {
        logic        iv;
        logic [15:0] alu;
        logic        pc;
        logic        rw;
        logic        exp_ov;
        logic [15:0] exp_alu;
        logic        exp_pcw;
        logic        exp_rww;
    } vec_t;

    logic        clk, rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [23:0] RD, ReadData;
    logic [15:0] ALUOutM, AluOutW;
    logic [3:0]  WA3M, WA3W;
    logic        PCSrcM, regWriteM, memToRegM, PCSrcW, regWriteW, memToRegW;

    logic        in_valid_w, in_ready_w, flush_w, out_valid_w, out_ready_w;
    logic [31:0] RD_w, ReadData_w, ALUOutM_w, AluOutW_w;
    logic [4:0]  WA3M_w, WA3W_w;
    logic        PCSrcW_w, regWriteW_w, memToRegW_w;

    int errors = 0;
    int checks = 0;
    item_t q[$];

    mem_wb_stage_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .RD(RD), .ALUOutM(ALUOutM), .WA3M(WA3M), .PCSrcM(PCSrcM), .regWriteM(regWriteM),
        .memToRegM(memToRegM), .out_valid(out_valid), .out_ready(out_ready),
        .ReadData(ReadData), .AluOutW(AluOutW), .WA3W(WA3W), .PCSrcW(PCSrcW),
        .regWriteW(regWriteW), .memToRegW(memToRegW)
    );

    mem_wb_stage_reg #(.DATA_W(32), .ALU_W(32), .RA_W(5)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .flush(flush_w),
        .RD(RD_w), .ALUOutM(ALUOutM_w), .WA3M(WA3M_w), .PCSrcM(1'b0), .regWriteM(1'b1),
        .memToRegM(1'b0), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .ReadData(ReadData_w), .AluOutW(AluOutW_w), .WA3W(WA3W_w), .PCSrcW(PCSrcW_w),
        .regWriteW(regWriteW_w), .memToRegW(memToRegW_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [23:0] rd, input logic [15:0] alu,
                                 input logic [3:0] wa, input logic pc,
                                 input logic rw, input logic m2r);
        item_t it;
        it.rd = rd; it.alu = alu; it.wa = wa; it.pc = pc; it.rw = rw; it.m2r = m2r;
        return it;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance both.
    // Entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic iv, input logic ordy, input logic fl, input item_t it);
        item_t h;
        logic  exp_ready;
        in_valid = iv; out_ready = ordy; flush = fl;
        RD = it.rd; ALUOutM = it.alu; WA3M = it.wa;
        PCSrcM = it.pc; regWriteM = it.rw; memToRegM = it.m2r;
        #2;
`ifdef MEM_WB_SKID_EN
        exp_ready = (q.size() < 2);
`else
        exp_ready = ordy || (q.size() == 0);
`endif
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            h = q[0];
            chk("ReadData", 64'(ReadData), 64'(h.rd));
            chk("AluOutW", 64'(AluOutW), 64'(h.alu));
            chk("WA3W", 64'(WA3W), 64'(h.wa));
            chk("memToRegW", 64'(memToRegW), 64'(h.m2r));
            chk("PCSrcW", 64'(PCSrcW), 64'(h.pc));
            chk("regWriteW", 64'(regWriteW), 64'(h.rw));
        end else begin
            chk("PCSrcW_bubble", 64'(PCSrcW), 64'd0);
            chk("regWriteW_bubble", 64'(regWriteW), 64'd0);
        end
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && exp_ready) q.push_back(it);
        end
        #1;
    endtask

    vec_t  tbl[5];
    item_t a_it, b_it;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        RD = '0; ALUOutM = '0; WA3M = '0; PCSrcM = 1'b0; regWriteM = 1'b0; memToRegM = 1'b0;
        in_valid_w = 1'b0; flush_w = 1'b0; out_ready_w = 1'b1;
        RD_w = '0; ALUOutM_w = '0; WA3M_w = '0;

        tbl[0] = '{1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'd2, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 16'd4, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'd5, 1'b1, 1'b0, 1'b1, 16'd5, 1'b1, 1'b0};

        // Power-on reset state.
        #3;
        chk("por_out_valid", 64'(out_valid), 64'd0);
        chk("por_in_ready", 64'(in_ready), 64'd0);
        chk("por_AluOutW", 64'(AluOutW), 64'd0);
        chk("por_regWriteW", 64'(regWriteW), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Streaming and bubble gating from the vector table.
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].iv, 1'b1, 1'b0, mk(24'h0, tbl[i].alu, 4'h1, tbl[i].pc, tbl[i].rw, 1'b0));
            chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) chk("tbl_AluOutW", 64'(AluOutW), 64'(tbl[i].exp_alu));
            chk("tbl_PCSrcW", 64'(PCSrcW), 64'(tbl[i].exp_pcw));
            chk("tbl_regWriteW", 64'(regWriteW), 64'(tbl[i].exp_rww));
            chk("tbl_in_ready", 64'(in_ready), 64'd1);
        end
        cycle(1'b0, 1'b1, 1'b0, mk(24'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0));

        // Stall: A held, B queued behind it, delivered A then B.
        a_it = mk(24'hAAAAAA, 16'h000A, 4'h5, 1'b0, 1'b1, 1'b1);
        b_it = mk(24'hBBBBBB, 16'h000B, 4'h6, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, a_it);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, b_it);
            chk("stall_WA3W", 64'(WA3W), 64'h5);
            chk("stall_regWriteW", 64'(regWriteW), 64'd1);
            chk("stall_AluOutW", 64'(AluOutW), 64'h000A);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        cycle(1'b1, 1'b1, 1'b0, b_it);
        chk("stall_rel_valid", 64'(out_valid), 64'd1);
        chk("stall_rel_B", 64'(AluOutW), 64'h000B);
        cycle(1'b0, 1'b1, 1'b0, b_it);
        chk("stall_empty", 64'(out_valid), 64'd0);

        // Flush drops the held entry and the one offered alongside it.
        cycle(1'b1, 1'b1, 1'b0, mk(24'h111111, 16'h00E0, 4'h2, 1'b1, 1'b1, 1'b0));
        chk("flush_pre_PCSrcW", 64'(PCSrcW), 64'd1);
        cycle(1'b1, 1'b1, 1'b1, mk(24'h222222, 16'h00CC, 4'h3, 1'b1, 1'b1, 1'b0));
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_PCSrcW", 64'(PCSrcW), 64'd0);
        chk("flush_regWriteW", 64'(regWriteW), 64'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0, mk(24'h0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b0));
            chk("flush_C_never", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset in the middle of a transfer.
        cycle(1'b1, 1'b0, 1'b0, mk(24'hABCDEF, 16'h1234, 4'h9, 1'b1, 1'b1, 1'b1));
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_ReadData", 64'(ReadData), 64'd0);
        chk("rst_AluOutW", 64'(AluOutW), 64'd0);
        chk("rst_WA3W", 64'(WA3W), 64'd0);
        chk("rst_PCSrcW", 64'(PCSrcW), 64'd0);
        chk("rst_regWriteW", 64'(regWriteW), 64'd0);
        chk("rst_memToRegW", 64'(memToRegW), 64'd0);
        q.delete();
        #2 rst = 1'b1;
        #1;
        chk("rst_rel_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rel_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Wide-parameter instance.
        in_valid_w = 1'b1; RD_w = 32'hDEADBEEF; WA3M_w = 5'd31; ALUOutM_w = 32'h89ABCDEF;
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        chk("wide_out_valid", 64'(out_valid_w), 64'd1);
        chk("wide_ReadData", 64'(ReadData_w), 64'hDEADBEEF);
        chk("wide_WA3W", 64'(WA3W_w), 64'd31);
        chk("wide_AluOutW", 64'(AluOutW_w), 64'h89ABCDEF);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0,
                  mk(24'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
